// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiply/divide for the execute stage.
// Radix-2 shift-add multiply or restoring divide, one bit per cycle over W cycles.
// The result is presented as a one-cycle register-file write.
module mul_div_unit #(
    parameter int unsigned W = 16,
    parameter int unsigned D = 4
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] ReadA,
    input  logic [W-1:0] ReadB,
    input  logic [D-1:0] destReg,
    output logic         busy,
    output logic         done,
    output logic         RegWrite,
    output logic [D-1:0] writeReg,
    output logic [W-1:0] writeValue
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_op;
    logic [D-1:0]   r_dest;
    logic [W-1:0]   r_b;
    // r_acc holds the product high half (MUL) or the partial remainder (DIV).
    // r_q holds the product low half (MUL) or the quotient (DIV).
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_q;

    logic [W:0]     w_mul_sum;
    logic [W-1:0]   w_mul_hi;
    logic [W-1:0]   w_mul_lo;
    logic [W:0]     w_div_sh;
    logic           w_div_ge;
    logic [W-1:0]   w_div_r;
    logic [W-1:0]   w_div_q;
    logic [W-1:0]   w_acc_nxt;
    logic [W-1:0]   w_q_nxt;
    logic [W-1:0]   w_result;

    // One iteration of both algorithms; the latched op picks which one advances.
    // The remainder fits in W bits after every step (it stays below the divisor,
    // or is a pure shift when no subtraction happens), so only W bits are stored.
    always_comb begin
        w_mul_sum = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_b : W'(0))};
        w_mul_hi  = w_mul_sum[W:1];
        w_mul_lo  = {w_mul_sum[0], r_q[W-1:1]};
        w_div_sh  = {r_acc, r_q[W-1]};
        w_div_ge  = (w_div_sh >= {1'b0, r_b});
        w_div_r   = w_div_ge ? (w_div_sh[W-1:0] - r_b) : w_div_sh[W-1:0];
        w_div_q   = {r_q[W-2:0], w_div_ge};
        w_acc_nxt = r_op[1] ? w_div_r : w_mul_hi;
        w_q_nxt   = r_op[1] ? w_div_q : w_mul_lo;
        // MUL/DIVU take the low/quotient half, MULHU/REMU the high/remainder half.
        w_result  = r_op[0] ? w_acc_nxt : w_q_nxt;
    end

    // Control FSM, datapath registers and registered register-file write port.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_dest     <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            RegWrite   <= 1'b0;
            writeReg   <= '0;
            writeValue <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done       <= 1'b0;
                    RegWrite   <= 1'b0;
                    writeReg   <= '0;
                    writeValue <= '0;
                    if (start) begin
                        r_op    <= op;
                        r_dest  <= destReg;
                        r_b     <= ReadB;
                        r_acc   <= '0;
                        r_q     <= ReadA;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W - 1)) begin
                        done       <= 1'b1;
                        RegWrite   <= (r_dest != '0);
                        writeReg   <= r_dest;
                        writeValue <= w_result;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    RegWrite   <= 1'b0;
                    writeReg   <= '0;
                    writeValue <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    RegWrite   <= 1'b0;
                    writeReg   <= '0;
                    writeValue <= '0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

    localparam int unsigned W = 16;
    localparam int unsigned D = 4;

    logic         CLK;
    logic         Reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] ReadA;
    logic [W-1:0] ReadB;
    logic [D-1:0] destReg;
    logic         busy;
    logic         done;
    logic         RegWrite;
    logic [D-1:0] writeReg;
    logic [W-1:0] writeValue;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.W(W), .D(D)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .start      (start),
        .op         (op),
        .ReadA      (ReadA),
        .ReadB      (ReadB),
        .destReg    (destReg),
        .busy       (busy),
        .done       (done),
        .RegWrite   (RegWrite),
        .writeReg   (writeReg),
        .writeValue (writeValue)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count one comparison and report it when observed differs from expected.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result from ordinary unsigned arithmetic.
    function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        case (o)
            2'd0:    return p[W-1:0];
            2'd1:    return p[2*W-1:W];
            2'd2:    return (b == '0) ? {W{1'b1}} : W'(a / b);
            default: return (b == '0) ? a : W'(a % b);
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " busy"},       32'(busy),       32'd0);
        check_eq({tag, " done"},       32'(done),       32'd0);
        check_eq({tag, " RegWrite"},   32'(RegWrite),   32'd0);
        check_eq({tag, " writeReg"},   32'(writeReg),   32'd0);
        check_eq({tag, " writeValue"}, 32'(writeValue), 32'd0);
    endtask

    // Issue one operation, scramble the inputs afterwards, and check latency and the write.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [D-1:0] dst, input bit poke, input string tag);
        logic [W-1:0] exp_val;
        int  cyc;
        bit  seen;
        bit  bad_phase;
        exp_val = ref_result(o, a, b);
        @(negedge CLK);
        op = o; ReadA = a; ReadB = b; destReg = dst; start = 1'b1;
        @(posedge CLK); #1;
        check_eq({tag, " busy after accept"}, 32'(busy), 32'd1);
        start   = 1'b0;
        op      = 2'($urandom);
        ReadA   = W'($urandom);
        ReadB   = W'($urandom);
        destReg = D'($urandom);
        cyc = 0; seen = 1'b0; bad_phase = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge CLK); #1;
            cyc++;
            if (done) seen = 1'b1;
            else if (RegWrite || !busy || writeValue != '0) bad_phase = 1'b1;
            if (poke && cyc == 5) begin
                start = 1'b1; op = 2'($urandom); ReadA = W'($urandom);
                ReadB = W'($urandom); destReg = D'($urandom | 1);
            end
            if (poke && cyc == 7) start = 1'b0;
        end
        start = 1'b0;
        check_eq({tag, " done latency"},   32'(cyc),        32'(W));
        check_eq({tag, " quiet in BUSY"},  32'(bad_phase),  32'd0);
        check_eq({tag, " RegWrite"},       32'(RegWrite),   32'(dst != '0));
        check_eq({tag, " writeReg"},       32'(writeReg),   32'(dst));
        check_eq({tag, " writeValue"},     32'(writeValue), 32'(exp_val));
        check_eq({tag, " busy in DONE"},   32'(busy),       32'd1);
        @(posedge CLK); #1;
        check_idle_outputs({tag, " after DONE"});
        if (poke) begin
            repeat (3) @(posedge CLK);
            #1;
            check_eq({tag, " no queued op"}, 32'(busy | done | RegWrite), 32'd0);
        end
    endtask

    // Watchdog so a stuck design still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0; start = 1'b0; op = '0; ReadA = '0; ReadB = '0; destReg = '0;
        #2 Reset = 1'b1;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;

        run_op(2'd0, 16'd300,  16'd200, 4'd3, 1'b0, "mul 300x200");
        run_op(2'd1, 16'd300,  16'd200, 4'd3, 1'b0, "mulhu 300x200");
        run_op(2'd1, 16'hFFFF, 16'hFFFF, 4'd5, 1'b0, "mulhu ffff");
        run_op(2'd0, 16'hFFFF, 16'hFFFF, 4'd5, 1'b0, "mul ffff");
        run_op(2'd2, 16'd1000, 16'd7,   4'd6, 1'b0, "divu 1000/7");
        run_op(2'd3, 16'd1000, 16'd7,   4'd6, 1'b0, "remu 1000/7");
        run_op(2'd2, 16'h1234, 16'd0,   4'd7, 1'b0, "divu by 0");
        run_op(2'd3, 16'h1234, 16'd0,   4'd7, 1'b0, "remu by 0");
        run_op(2'd0, 16'd2,    16'd3,   4'd0, 1'b0, "mul to r0");
        run_op(2'd0, 16'd123,  16'd45,  4'd9, 1'b1, "start ignored in BUSY");

        // Abort an operation part-way through with an asynchronous reset.
        @(negedge CLK);
        op = 2'd0; ReadA = 16'd77; ReadB = 16'd99; destReg = 4'd2; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (8) @(posedge CLK);
        #2 Reset = 1'b1;
        #1;
        check_idle_outputs("async abort");
        repeat (3) @(posedge CLK);
        #1;
        check_eq("abort no done", 32'(done | RegWrite), 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("abort stays idle", 32'(busy | done | RegWrite), 32'd0);
        run_op(2'd0, 16'd5, 16'd5, 4'd4, 1'b0, "mul 5x5 after reset");

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (i % 6 == 5) ? W'(0) : ((i % 3 == 0) ? W'($urandom_range(1, 300)) : W'($urandom));
            run_op(2'(i % 4), ra, rb, D'($urandom), 1'b0, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
